// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/PC-sequencing stage: state encoding,
// opcode values for decode and benches, and width/increment constants.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch/JAL,
// or register-indirect JALR target, with word-alignment detection.
module next_pc_calc
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br,
  input  logic        pc_to_reg,
  input  logic        alu_to_pc,
  input  logic        br_cond,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic        taken;
  logic [31:0] target;

  // Select the candidate PC; JAL/JALR are taken regardless of the comparator.
  always_comb begin
    pc_plus4 = pc + PC_INC;
    taken    = br & (pc_to_reg | br_cond);
    if (alu_to_pc) begin
      target = alu_result & 32'hFFFF_FFFE;
    end else begin
      target = pc + imm;
    end
    if (taken) begin
      next_pc = target;
    end else begin
      next_pc = pc_plus4;
    end
    misaligned = is_misaligned(next_pc);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch and PC-sequencing stage: fetches over req/ack, presents
// the instruction for one EXEC cycle, then commits the next PC.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               br,
  input  logic               pc_to_reg,
  input  logic               alu_to_pc,
  input  logic               halt,
  input  logic               br_cond,
  input  logic [31:0]        imm,
  input  logic [31:0]        alu_result,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  state_t          state;
  state_t          state_next;
  logic [TO_W-1:0] to_cnt;
  logic            to_expire;
  logic [31:0]     next_pc;
  logic            misaligned;
  logic [CNT_W-1:0] retired_inc;

  next_pc_calc u_next_pc (
    .pc         (pc),
    .br         (br),
    .pc_to_reg  (pc_to_reg),
    .alu_to_pc  (alu_to_pc),
    .br_cond    (br_cond),
    .imm        (imm),
    .alu_result (alu_result),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  assign to_expire   = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign retired_inc = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);
  assign imem_addr   = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; decode inputs are only looked at in EXEC.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = ST_EXEC;
        end else if (to_expire) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (halt || misaligned) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_FETCH;
    endcase
  end

  // Architectural state: PC, latched instruction, sticky flags, retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      instr   <= '0;
      halted  <= 1'b0;
      fault   <= 1'b0;
      retired <= '0;
      to_cnt  <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_expire) begin
              fault  <= 1'b1;
              halted <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (halt) begin
            halted  <= 1'b1;
            retired <= retired_inc;
          end else if (misaligned) begin
            fault  <= 1'b1;
            halted <= 1'b1;
          end else begin
            pc      <= next_pc;
            retired <= retired_inc;
            to_cnt  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table of instructions with
// hand-computed next PCs, scoreboard on instr_valid, plus corner sequences.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        br = 1'b0, pc_to_reg = 1'b0, alu_to_pc = 1'b0, halt = 1'b0, br_cond = 1'b0;
  logic [31:0] imm = 32'h0, alu_result = 32'h0;
  logic        halted, fault;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .br(br),
    .pc_to_reg(pc_to_reg), .alu_to_pc(alu_to_pc), .halt(halt),
    .br_cond(br_cond), .imm(imm), .alu_result(alu_result),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          waits;
    logic        br, ptr, atp, hlt, cond;
    logic [31:0] imm, alu;
    logic [31:0] exp_next;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic        exp_halted, exp_fault;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every EXEC cycle must match one fetched word, in order.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_valid: got instr 0x%0h expected no valid", instr);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_instr", {32'h0, instr}, {32'h0, e.word});
        chk("sb_pc", {32'h0, pc}, {32'h0, e.pc});
        chk("sb_pc_plus4", {32'h0, pc_plus4}, {32'h0, e.pc + 32'd4});
      end
    end
  end

  task automatic scramble_decode();
    br = 1'($urandom); pc_to_reg = 1'($urandom); alu_to_pc = 1'($urandom);
    halt = 1'($urandom); br_cond = 1'($urandom);
    imm = $urandom; alu_result = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0; exp_ret = 32'h0; exp_halted = 1'b0; exp_fault = 1'b0;
    chk("rst_pc", {32'h0, pc}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_req_valid", {62'h0, imem_req, instr_valid}, 64'h2);
    chk("rst_flags", {62'h0, halted, fault}, 64'h0);
    chk("rst_retired", {32'h0, retired}, 64'h0);
  endtask

  task automatic run_vec(input vec_t v);
    chk("fetch_req_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, exp_pc});
    for (int i = 0; i < v.waits; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("wait_stable", {30'h0, imem_req, instr_valid, imem_addr}, {30'h0, 2'b10, exp_pc});
    end
    imem_ack = 1'b1; imem_rdata = v.word;
    sb.push_back('{pc: exp_pc, word: v.word});
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
    chk("exec_valid_req", {62'h0, instr_valid, imem_req}, 64'h2);
    br = v.br; pc_to_reg = v.ptr; alu_to_pc = v.atp; halt = v.hlt; br_cond = v.cond;
    imm = v.imm; alu_result = v.alu;
    @(negedge clk);
    scramble_decode();
    if (v.hlt) begin
      exp_halted = 1'b1; exp_ret = exp_ret + 32'd1;
    end else if (v.exp_fault) begin
      exp_halted = 1'b1; exp_fault = 1'b1;
    end else begin
      exp_pc = v.exp_next; exp_ret = exp_ret + 32'd1;
    end
    chk("commit_pc", {32'h0, pc}, {32'h0, exp_pc});
    chk("commit_retired", {32'h0, retired}, {32'h0, exp_ret});
    chk("commit_flags", {62'h0, halted, fault}, {62'h0, exp_halted, exp_fault});
  endtask

  vec_t tbl[$];
  vec_t hv;
  int   bad;

  initial begin
    //       word          w  br ptr atp hlt cnd imm            alu            next           flt
    tbl.push_back('{32'h0000_0033, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0004, 0});
    tbl.push_back('{32'h0020_81B3, 0, 0, 0, 0, 0, 1, 32'h10,        32'h3,         32'h0000_0008, 0});
    tbl.push_back('{32'h4020_81B3, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_000C, 0});
    tbl.push_back('{32'h0020_F1B3, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0010, 0});
    tbl.push_back('{32'hFE00_0CE3, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,         32'h0000_0014, 0});
    tbl.push_back('{32'hFE00_0EE3, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0,         32'h0000_0010, 0});
    tbl.push_back('{32'hFE00_0CE3, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008, 0});
    tbl.push_back('{32'h0000_0463, 0, 1, 0, 0, 0, 1, 32'h8,         32'h0,         32'h0000_0010, 0});
    tbl.push_back('{32'h0200_006F, 0, 1, 1, 0, 0, 0, 32'h20,        32'h0,         32'h0000_0030, 0});
    tbl.push_back('{32'h0000_0033, 3, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0034, 0});
    tbl.push_back('{32'h0000_8067, 0, 1, 1, 1, 0, 0, 32'h100,       32'h41,        32'h0000_0040, 0});
    tbl.push_back('{32'h0000_8067, 0, 1, 1, 1, 0, 1, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 0});
    tbl.push_back('{32'h0000_0033, 2, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0000, 0});
    tbl.push_back('{32'h0000_8067, 0, 1, 1, 1, 0, 0, 32'h0,         32'h42,        32'h0000_0000, 1});

    do_reset();
    foreach (tbl[i]) run_vec(tbl[i]);

    // Halt with br asserted: halt wins, then stays frozen with ack ignored.
    do_reset();
    hv = '{32'h0000_007F, 0, 1, 0, 0, 1, 1, 32'h8, 32'h0, 32'h0, 0};
    run_vec(hv);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom; scramble_decode();
      @(negedge clk);
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 ||
          halted !== 1'b1 || retired !== 32'd1) bad++;
    end
    imem_ack = 1'b0;
    chk("halted_frozen_bad_cycles", 64'(bad), 64'h0);

    // Reset exits HALTED and fetch resumes.
    do_reset();
    hv = '{32'h0000_0013, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0};
    run_vec(hv);

    // Fetch timeout: fault exactly after 16 ack-less FETCH cycles.
    do_reset();
    for (int i = 0; i < 15; i++) @(negedge clk);
    chk("timeout_before", {61'h0, fault, halted, imem_req}, 64'h1);
    @(negedge clk);
    chk("timeout_after", {61'h0, fault, halted, imem_req}, 64'h6);
    chk("timeout_pc", {32'h0, pc}, 64'h0);

    // Reset mid-fetch with an ack coinciding with rst.
    do_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0;
    chk("midrst_instr", {32'h0, instr}, 64'h0);
    chk("midrst_req_valid_addr", {30'h0, imem_req, instr_valid, imem_addr}, {30'h0, 2'b10, 32'h0});
    hv = '{32'h0000_0033, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0};
    run_vec(hv);

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
